// File: rtl/fragment_blend_fetch.sv
// Read-modify-write front end for the color blender: issues destination reads,
// aligns source/destination for the blender and writes results back in order.
module fragment_blend_fetch #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH      = 16,
    parameter int READ_LATENCY    = 1,
    parameter int BLEND_LATENCY   = 1,
    parameter int PIXEL_WIDTH     = 4 * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   blend_enable,
    input  logic                   s_frag_tvalid,
    output logic                   s_frag_tready,
    input  logic [ADDR_WIDTH-1:0]  s_frag_taddr,
    input  logic [PIXEL_WIDTH-1:0] s_frag_tcolor,
    input  logic [3:0]             s_frag_tmask,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [PIXEL_WIDTH-1:0] rd_data,
    output logic [PIXEL_WIDTH-1:0] blend_src,
    output logic [PIXEL_WIDTH-1:0] blend_dst,
    input  logic [PIXEL_WIDTH-1:0] blend_color,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] wr_data,
    output logic [3:0]             wr_mask,
    output logic                   idle
);
    localparam int D = READ_LATENCY + BLEND_LATENCY;

    // Stage k holds the fragment accepted k cycles ago (k = 1..D).
    logic                   r_vld   [1:D];
    logic [ADDR_WIDTH-1:0]  r_addr  [1:D];
    logic [PIXEL_WIDTH-1:0] r_color [1:D];
    logic [3:0]             r_mask  [1:D];

    // Output stage doubles as hazard entry D+1; tracked even when the mask is empty.
    logic                   r_out_vld;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [PIXEL_WIDTH-1:0] r_wr_data;
    logic [3:0]             r_wr_mask;

    logic w_hazard;
    logic w_busy;
    logic w_accept;

    always_comb begin
        w_hazard = 1'b0;
        w_busy   = r_out_vld;
        for (int k = 1; k <= D; k++) begin
            if (r_vld[k]) begin
                w_busy = 1'b1;
                if (r_addr[k] == s_frag_taddr) begin
                    w_hazard = 1'b1;
                end
            end
        end
        if (r_out_vld && (r_wr_addr == s_frag_taddr)) begin
            w_hazard = 1'b1;
        end
    end

    assign s_frag_tready = !reset && !(blend_enable && w_hazard);
    assign w_accept      = s_frag_tvalid && s_frag_tready;

    assign rd_en     = w_accept && blend_enable;
    assign rd_addr   = s_frag_taddr;
    assign blend_src = r_color[READ_LATENCY];
    assign blend_dst = rd_data;

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign wr_mask = r_wr_mask;
    assign idle    = !w_busy;

    always_ff @(posedge aclk) begin
        r_addr[1]  <= s_frag_taddr;
        r_color[1] <= s_frag_tcolor;
        r_mask[1]  <= s_frag_tmask;
        for (int k = 2; k <= D; k++) begin
            r_addr[k]  <= r_addr[k-1];
            r_color[k] <= r_color[k-1];
            r_mask[k]  <= r_mask[k-1];
        end
        if (reset) begin
            for (int k = 1; k <= D; k++) begin
                r_vld[k] <= 1'b0;
            end
            r_out_vld <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_mask <= '0;
        end else begin
            r_vld[1] <= w_accept;
            for (int k = 2; k <= D; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_out_vld <= r_vld[D];
            r_wr_en   <= r_vld[D] && (r_mask[D] != 4'b0000);
            r_wr_addr <= r_addr[D];
            r_wr_data <= blend_enable ? blend_color : r_color[D];
            r_wr_mask <= r_mask[D];
        end
    end
endmodule

// File: tb/tb_fragment_blend_fetch.sv
// Self-checking bench: behavioural color-buffer/blender environment plus a
// per-cycle reference model of accepted fragments, reads and write-backs.
module tb_fragment_blend_fetch;
    localparam int RL = 1;
    localparam int D  = 2;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        blend_enable = 1'b1;
    logic        s_frag_tvalid = 1'b0;
    logic        s_frag_tready;
    logic [15:0] s_frag_taddr = '0;
    logic [31:0] s_frag_tcolor = '0;
    logic [3:0]  s_frag_tmask = '0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] blend_src, blend_dst, blend_color;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        idle;

    fragment_blend_fetch dut (
        .aclk(aclk), .reset(reset), .blend_enable(blend_enable),
        .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready),
        .s_frag_taddr(s_frag_taddr), .s_frag_tcolor(s_frag_tcolor), .s_frag_tmask(s_frag_tmask),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .blend_src(blend_src), .blend_dst(blend_dst), .blend_color(blend_color),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .idle(idle)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {4{a[7:0]}};
    endfunction

    function automatic logic [31:0] blend_fn(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i*8 +: 8] + d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    // Color buffer (old data on read-during-write) and one-cycle blender.
    logic [31:0] cbuf [65536];
    bit          cw   [65536];
    logic [31:0] rd_q, blend_q;
    assign rd_data     = rd_q;
    assign blend_color = blend_q;

    always_ff @(posedge aclk) begin
        if (rd_en) rd_q <= cw[rd_addr] ? cbuf[rd_addr] : init_val(rd_addr);
        if (wr_en) begin
            cbuf[wr_addr] <= merge(cw[wr_addr] ? cbuf[wr_addr] : init_val(wr_addr), wr_data, wr_mask);
            cw[wr_addr]   <= 1'b1;
        end
        blend_q <= blend_fn(blend_src, blend_dst);
    end

    // Reference model: slot[c & 7] describes the fragment accepted in cycle c.
    logic [31:0] mmem [65536];
    bit          sv   [8];
    logic [15:0] sa   [8];
    logic [31:0] sc   [8];
    logic [3:0]  sm   [8];
    logic [31:0] sdst [8];
    logic [31:0] sd   [8];
    bit          sbe  [8];

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    bit last_acc;
    int last_wr_cycle = -1;
    logic [31:0] last_wr_data;
    logic [3:0]  last_wr_mask;
    int wr_count = 0;
    logic [31:0] obs_dst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rs, input bit vv, input logic [15:0] a,
                        input logic [31:0] col, input logic [3:0] m);
        bit hz, acc, exp_idle;
        int s;
        reset = rs; s_frag_tvalid = vv; s_frag_taddr = a; s_frag_tcolor = col; s_frag_tmask = m;
        #3;
        hz = 1'b0;
        exp_idle = 1'b1;
        for (int k = 1; k <= D + 1; k++) begin
            s = (cyc - k) & 7;
            if (sv[s]) begin
                exp_idle = 1'b0;
                if (sa[s] == a) hz = 1'b1;
            end
        end
        chk("tready", s_frag_tready, !rs && !(blend_enable && hz));
        acc = vv && !rs && !(blend_enable && hz);
        chk("rd_en", rd_en, acc && blend_enable);
        if (acc && blend_enable) chk("rd_addr", rd_addr, a);
        s = (cyc - RL) & 7;
        if (sv[s]) begin
            chk("blend_src", blend_src, sc[s]);
            if (sbe[s]) chk("blend_dst", blend_dst, sdst[s]);
        end
        obs_dst = blend_dst;
        s = (cyc - D - 1) & 7;
        if (sv[s] && sm[s] != 4'b0000) begin
            chk("wr_en", wr_en, 1'b1);
            chk("wr_addr", wr_addr, sa[s]);
            chk("wr_data", wr_data, sd[s]);
            chk("wr_mask", wr_mask, sm[s]);
            mmem[sa[s]] = merge(mmem[sa[s]], sd[s], sm[s]);
        end else begin
            chk("wr_en_idle", wr_en, 1'b0);
        end
        chk("idle", idle, exp_idle);
        if (wr_en) begin
            last_wr_cycle = cyc; last_wr_data = wr_data; last_wr_mask = wr_mask; wr_count++;
        end
        s = cyc & 7;
        sv[s] = acc; sa[s] = a; sc[s] = col; sm[s] = m; sbe[s] = blend_enable;
        sdst[s] = mmem[a];
        sd[s] = blend_enable ? blend_fn(col, mmem[a]) : col;
        if (rs) for (int i = 0; i < 8; i++) sv[i] = 1'b0;
        last_acc = acc;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'hffff, 32'h0, 4'h0);
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] col, input logic [3:0] m,
                        output int stalls, output int acc_cycle);
        stalls = 0;
        acc_cycle = -1;
        for (int i = 0; i < 10; i++) begin
            acc_cycle = cyc;
            step(1'b0, 1'b1, a, col, m);
            if (last_acc) break;
            stalls++;
        end
        if (!last_acc) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int st, t0, t1, wc0, nacc;
        for (int i = 0; i < 65536; i++) mmem[i] = init_val(i[15:0]);
        for (int i = 0; i < 8; i++) sv[i] = 1'b0;
        @(posedge aclk);
        #1;
        cyc = 1;
        step(1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
        chk("reset_wr_data", wr_data, 32'h0);
        chk("reset_wr_addr", wr_addr, 16'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

        // Same-address pair at 0x0042 with blending.
        blend_enable = 1'b1;
        push(16'h0042, 32'h01020304, 4'hf, st, t0);
        push(16'h0042, 32'h01010101, 4'hf, st, t1);
        chk("first_write_latency", last_wr_cycle - t0, 3);
        chk("first_wr_data", last_wr_data, 32'h43444546);
        chk("hazard_stalls", st, 3);
        chk("reaccept_after_write", t1 - last_wr_cycle, 1);
        step(1'b0, 1'b0, 16'hffff, 32'h0, 4'h0);
        chk("second_rd_data", obs_dst, 32'h43444546);
        idle_cycles(4);

        // Back-to-back distinct addresses.
        wc0 = wr_count;
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, i[15:0], $urandom, 4'hf);
            nacc += int'(last_acc);
        end
        idle_cycles(4);
        chk("stream_accepts", nacc, 16);
        chk("stream_writes", wr_count - wc0, 16);

        // Pass-through without blending.
        blend_enable = 1'b0;
        push(16'h0042, 32'h11223344, 4'b1010, st, t0);
        idle_cycles(4);
        chk("nb_latency", last_wr_cycle - t0, 3);
        chk("nb_wr_data", last_wr_data, 32'h11223344);
        chk("nb_wr_mask", last_wr_mask, 4'b1010);

        // Empty mask still tracks its address.
        blend_enable = 1'b1;
        wc0 = wr_count;
        push(16'h0007, 32'haabbccdd, 4'h0, st, t0);
        push(16'h0007, 32'h01010101, 4'hf, st, t1);
        chk("mask0_stalls", st, 3);
        chk("mask0_no_write", wr_count - wc0, 0);
        idle_cycles(4);

        // Reset while two fragments are in flight.
        wc0 = wr_count;
        push(16'h0001, 32'h0, 4'hf, st, t0);
        push(16'h0002, 32'h0, 4'hf, st, t1);
        step(1'b1, 1'b0, 16'h0, 32'h0, 4'h0);
        step(1'b0, 1'b0, 16'h0001, 32'h0, 4'h0);
        idle_cycles(4);
        chk("reset_discards", wr_count - wc0, 0);

        // Randomized traffic, blend mode changed only between drained blocks.
        for (int b = 0; b < 6; b++) begin
            blend_enable = b[0];
            for (int i = 0; i < 200; i++) begin
                logic [3:0] m;
                m = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
                step(1'b0, ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 7)), $urandom, m);
            end
            idle_cycles(4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
